// File: rtl/put_motion_code.sv
// MPEG-2 motion_code VLC encoder: looks up the Table B-10 codeword for a signed
// motion_code and shifts it out MSB first over a valid/ready bit interface.
module put_motion_code (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [5:0] motion_code,
  output logic       bit_out,
  output logic       bit_valid,
  input  logic       bit_ready,
  output logic       last,
  output logic [3:0] code_len,
  output logic       done,
  output logic       err
);

  localparam int unsigned CW = 11;
  localparam int unsigned LW = 4;
  localparam int unsigned MW = 6;

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e          state_q;
  logic [CW-1:0]   shreg_q;
  logic [LW-1:0]   cnt_q;
  logic [LW-1:0]   code_len_q;
  logic            in_ready_q;
  logic            bit_valid_q;
  logic            last_q;
  logic            done_q;
  logic            err_q;

  logic [MW-1:0]   mag_c;
  logic            legal_c;
  logic [CW-2:0]   prefix_c;
  logic [LW-1:0]   len_c;
  logic [CW-1:0]   code_c;
  logic [CW-1:0]   aligned_c;

  // Codeword lookup: prefix excludes the trailing sign bit, len includes it.
  always_comb begin
    mag_c    = motion_code[MW-1] ? MW'(-motion_code) : motion_code;
    legal_c  = (mag_c <= MW'(16));
    prefix_c = '0;
    len_c    = LW'(1);
    case (mag_c)
      6'd1:  begin prefix_c = (CW-1)'(1);  len_c = LW'(3);  end
      6'd2:  begin prefix_c = (CW-1)'(1);  len_c = LW'(4);  end
      6'd3:  begin prefix_c = (CW-1)'(1);  len_c = LW'(5);  end
      6'd4:  begin prefix_c = (CW-1)'(3);  len_c = LW'(7);  end
      6'd5:  begin prefix_c = (CW-1)'(5);  len_c = LW'(8);  end
      6'd6:  begin prefix_c = (CW-1)'(4);  len_c = LW'(8);  end
      6'd7:  begin prefix_c = (CW-1)'(3);  len_c = LW'(8);  end
      6'd8:  begin prefix_c = (CW-1)'(11); len_c = LW'(10); end
      6'd9:  begin prefix_c = (CW-1)'(10); len_c = LW'(10); end
      6'd10: begin prefix_c = (CW-1)'(9);  len_c = LW'(10); end
      6'd11: begin prefix_c = (CW-1)'(17); len_c = LW'(11); end
      6'd12: begin prefix_c = (CW-1)'(16); len_c = LW'(11); end
      6'd13: begin prefix_c = (CW-1)'(15); len_c = LW'(11); end
      6'd14: begin prefix_c = (CW-1)'(14); len_c = LW'(11); end
      6'd15: begin prefix_c = (CW-1)'(13); len_c = LW'(11); end
      6'd16: begin prefix_c = (CW-1)'(12); len_c = LW'(11); end
      default: begin prefix_c = '0; len_c = LW'(1); end
    endcase
    code_c    = (mag_c == '0) ? CW'(1) : {prefix_c, motion_code[MW-1]};
    aligned_c = code_c << (LW'(CW) - len_c);
  end

  // Control FSM and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      code_len_q  <= '0;
      in_ready_q  <= 1'b1;
      bit_valid_q <= 1'b0;
      last_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (legal_c) begin
              shreg_q     <= aligned_c;
              cnt_q       <= len_c;
              code_len_q  <= len_c;
              last_q      <= (len_c == LW'(1));
              bit_valid_q <= 1'b1;
              in_ready_q  <= 1'b0;
              state_q     <= SHIFT;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (bit_ready) begin
            shreg_q <= shreg_q << 1;
            cnt_q   <= cnt_q - LW'(1);
            last_q  <= (cnt_q == LW'(2));
            if (cnt_q == LW'(1)) begin
              state_q     <= IDLE;
              bit_valid_q <= 1'b0;
              in_ready_q  <= 1'b1;
              last_q      <= 1'b0;
              done_q      <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign bit_out   = shreg_q[CW-1];
  assign bit_valid = bit_valid_q;
  assign last      = last_q;
  assign code_len  = code_len_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: doc/put_motion_code.md
Name: put_motion_code

Overview:
MPEG-2 motion_code VLC encoder and bit serializer (Table B-10).
- Accepts one signed motion_code per transaction and looks up its codeword and length.
- Shifts the codeword out one bit per beat, MSB first, over a valid/ready bit interface to the bitstream writer.
- It is the write-side counterpart of get_motion_code, and its output must round-trip through that decoder.

Parameters:
- None. The codeword width is fixed at 11 bits, the length field at 4 bits, and motion_code at 6 bits signed.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  motion_code is presented
- in_ready  out  1  block can accept motion_code
- motion_code  in  6  signed (2's complement) value; legal range -16..+16
- bit_out  out  1  current serial bit
- bit_valid  out  1  bit_out is valid
- bit_ready  in  1  consumer takes bit_out this cycle
- last  out  1  bit_out is the final bit of the codeword
- code_len  out  4  length of the codeword being sent (1..11), registered at accept
- done  out  1  one-cycle pulse after the final bit is taken
- err  out  1  one-cycle pulse when an out-of-range motion_code is rejected

Behaviour:
Reset values:
- bit_valid=0, bit_out=0, last=0, code_len=0, done=0, err=0; state=IDLE, so in_ready=1.

Codeword table (value: bits, s=sign where 0 = positive, 1 = negative):
- 0: 1
- ±1: 01s
- ±2: 001s
- ±3: 0001s
- ±4: 000011s
- ±5: 0000101s
- ±6: 0000100s
- ±7: 0000011s
- ±8: 000001011s
- ±9: 000001010s
- ±10: 000001001s
- ±11: 0000010001s
- ±12: 0000010000s
- ±13: 0000001111s
- ±14: 0000001110s
- ±15: 0000001101s
- ±16: 0000001100s

Table rules:
- Magnitude is computed in 6 bits. -16 (6'b110000) is legal.
- The lookup is combinational.
- The codeword is left-aligned into an 11-bit shift register.

FSM with 2 states:
- IDLE:
  - in_ready=1, bit_valid=0.
  - On in_valid with |motion_code|<=16: load the shift register, set cnt=len and code_len=len, go to SHIFT.
  - On in_valid with |motion_code|>16: err=1 for the next cycle, stay in IDLE, emit no bits.
- SHIFT:
  - in_ready=0, bit_valid=1, bit_out=shreg[10], last=(cnt==1).
  - On bit_ready: shift left by 1 and decrement cnt.
  - If cnt was 1: go to IDLE and set done=1 for the next cycle.

Timing:
- The first bit_valid is asserted in the cycle after acceptance.
- Throughput is len+1 cycles per codeword with bit_ready held high.
- No input is accepted while in SHIFT; back-to-back acceptance is not supported.

Backpressure:
- While bit_valid=1 and bit_ready=0, bit_out, last and code_len hold stable.

Boundaries:
- A 1-bit code (motion_code=0) asserts last on its only beat.
- in_valid held high across SHIFT is ignored; the value is taken on return to IDLE.
- err and done never assert in the same cycle.

Reset mid-operation:
- Synchronous rst in any state aborts the codeword; the remaining bits are never emitted.
- In the next cycle bit_valid=0, in_ready=1, and done and err are not pulsed.

Test Plan:
1. motion_code=0, bit_ready=1 -> one beat with bit_out=1 and last=1, code_len=1; done pulses the following cycle; in_ready=1 again.
2. motion_code=+3, then -3, bit_ready=1 -> bit streams 00010 and 00011, code_len=5 each; last on beat 5; 6 cycles per codeword.
3. motion_code=-16, then +16 -> streams 00000011001 and 00000011000, code_len=11.
4. motion_code=+7 with bit_ready toggling 1,0,0,1,... -> bit_out and last stable during stalls; delivered sequence is 00000110; done only after beat 8 is taken.
5. motion_code=+20 (and -17) -> err one-cycle pulse, bit_valid stays 0, in_ready stays 1; a following motion_code=+1 gives 010 normally.
6. motion_code=-11; assert rst after 4 bits are taken -> next cycle bit_valid=0, in_ready=1, no done. Separately, a loop-back sweep of all values -16..+16 into get_motion_code must decode every value correctly, with outshift equal to code_len.
